aline_echo_capture: RTL and testbench
=====================================

// Module: aline_echo_capture
// PURPOSE
//  Downstream of image_transmit_fsm. Per A-line, captures AFE ADC echo samples while
//  afe_switch is high into an internal sample RAM, then drains the RAM as a framed byte
//  stream to the UART transmitter. Drives mem_clear, which image_transmit_fsm waits on
//  in NEXT_ALINE before it fires the next A-line.
// PARAMETERS
//  ADC_WIDTH  10    ADC sample width in bits (1..16)
//  DEPTH      1024  sample RAM depth = max samples per A-line
//  ADDR_W     10    RAM address width, must equal clog2(DEPTH)
//  HDR_BYTE   8'hA5 frame sync byte
// PORTS
//  clk                  in   1          system clock
//  rst                  in   1          synchronous, active-high reset
//  afe_switch           in   1          1 = AFE in receive window (from aline_transmit_fsm)
//  transmit_in_progress in   1          image-level busy from image_transmit_fsm
//  adc_data             in   ADC_WIDTH  ADC sample
//  adc_valid            in   1          adc_data valid this cycle
//  tx_data              out  8          byte to UART TX
//  tx_start             out  1          1-cycle pulse: load tx_data into UART
//  tx_busy              in   1          UART TX shifting; high the cycle after tx_start
//  mem_clear            out  1          level: RAM drained, ready for next A-line
//  capturing            out  1          high in CAPTURE
//  capture_missed       out  1          sticky: afe_switch rose while not IDLE
// BEHAVIOUR
//  Reset: state=IDLE, tx_data=0, tx_start=0, mem_clear=1, capturing=0, capture_missed=0,
//   wr_addr=0, sample_count=0, aline_idx=0, overflow=0. Reset mid-frame aborts; no partial
//   byte is re-sent.
//  afe_rise = afe_switch & ~afe_switch_q (registered prior value, reset 0).
//  States:
//   IDLE: on afe_rise -> CAPTURE; mem_clear<=0, wr_addr<=0, overflow<=0.
//   CAPTURE: adc_valid & wr_addr<DEPTH -> RAM[wr_addr]<=adc_data, wr_addr++.
//    adc_valid with DEPTH samples stored -> sample dropped, overflow<=1.
//    afe_switch==0 -> sample_count<=wr_addr (0..DEPTH, 16 bits), -> SEND.
//    Sample on the same cycle afe_switch falls is NOT stored.
//   SEND: byte sequence HDR_BYTE, {overflow,aline_idx[6:0]}, count[15:8], count[7:0],
//    then per sample i=0..count-1: hi={zero-pad,data[ADC_WIDTH-1:8]}, lo=data[7:0]
//    (ADC_WIDTH<=8: hi=8'h00). count==0 -> header only.
//   TX handshake: tx_start pulses 1 cycle with tx_data stable that cycle, only when
//    tx_busy==0 and no pulse in the previous cycle; tx_data holds until next pulse.
//    RAM read is 1-cycle synchronous; address issued before byte is needed, no bubbles
//    beyond the UART rate.
//   DONE: entered after last tx_start once tx_busy==0; mem_clear<=1, aline_idx++
//    (7-bit wrap 127->0), -> IDLE.
//  mem_clear stays 1 in IDLE until next afe_rise (level, safe for negedge sampling).
//  aline_idx<=0 whenever transmit_in_progress==0 in IDLE (new image restarts at 0).
//  afe_rise outside IDLE: ignored, capture_missed<=1 (cleared only by rst).
//  capturing = (state==CAPTURE).
// TESTING
//  1 rst; afe_switch high 5 cycles, adc_valid each, data 10'h3FF,1,2,3,4 -> bytes A5,00,
//    00,05,03,FF,00,01,00,02,00,03,00,04; mem_clear 0 during, 1 after last tx_busy fall.
//  2 DEPTH=4 build, 6 valid samples -> count=4, byte1=8'h80 (overflow), 8 data bytes.
//  3 afe_switch pulse with no adc_valid -> A5,idx,00,00 only; mem_clear returns to 1.
//  4 three A-lines with transmit_in_progress=1 -> idx bytes 00,01,02; drop
//    transmit_in_progress in IDLE -> next frame idx 00.
//  5 afe_rise during SEND -> capture_missed=1, frame bytes unchanged; tx_busy held high
//    20 cycles -> no tx_start until tx_busy==0.
//  6 rst asserted mid-SEND -> next cycle IDLE, mem_clear=1, tx_start=0, no further bytes.

Source files
------------

// File: rtl/aline_echo_capture.sv
// rtl/aline_echo_capture.sv - per-A-line ADC echo capture into RAM and framed UART drain
//
// Captures ADC samples while afe_switch is high, then sends one frame per A-line:
//   HDR_BYTE, {overflow, aline_idx[6:0]}, count[15:8], count[7:0],
//   then per sample a zero-padded high byte followed by the low byte.
// mem_clear is high whenever the RAM holds no undrained A-line.
//
// Ports:
//   clk                  system clock
//   rst                  synchronous active-high reset
//   afe_switch           1 = AFE receive window open
//   transmit_in_progress image-level busy; low in IDLE restarts the A-line index
//   adc_data/adc_valid   ADC sample and its qualifier
//   tx_data/tx_start     byte and 1-cycle load strobe towards the UART
//   tx_busy              UART shifting (high the cycle after tx_start)
//   mem_clear            level: RAM drained, ready for the next A-line
//   capturing            high while capturing samples
//   capture_missed       sticky: an A-line started while this block was busy

module aline_echo_capture #(
   parameter int         ADC_WIDTH = 10,
   parameter int         DEPTH     = 1024,
   parameter int         ADDR_W    = 10,
   parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 afe_switch,
   input  logic                 transmit_in_progress,
   input  logic [ADC_WIDTH-1:0] adc_data,
   input  logic                 adc_valid,
   output logic [7:0]           tx_data,
   output logic                 tx_start,
   input  logic                 tx_busy,
   output logic                 mem_clear,
   output logic                 capturing,
   output logic                 capture_missed
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SEND    = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

   state_t state;
   state_t state_nxt;

   logic                 afe_switch_q;
   logic                 afe_rise;
   logic [ADDR_W:0]      wr_addr;
   logic                 wr_full;
   logic [15:0]          sample_count;
   logic [6:0]           aline_idx;
   logic                 overflow;

   logic [ADC_WIDTH-1:0] mem [DEPTH];
   logic [ADC_WIDTH-1:0] rd_data;
   logic [ADDR_W-1:0]    rd_addr;
   logic [15:0]          rd_ext;

   logic [16:0]          byte_idx;
   logic [16:0]          byte_total;
   logic                 bytes_left;
   logic [7:0]           cur_byte;
   logic                 tx_start_q;
   logic [7:0]           tx_data_q;

   assign afe_rise   = afe_switch & ~afe_switch_q;
   assign wr_full    = (wr_addr == DEPTH_L);
   assign capturing  = (state == CAPTURE);

   // Frame length: 4 header bytes plus two bytes per stored sample.
   assign byte_total = {sample_count, 1'b0} + 17'd4;
   assign bytes_left = (byte_idx < byte_total);

   // Byte n (n >= 4) belongs to sample (n-4)/2 = n/2 - 2. The read address
   // follows byte_idx, which advances on the strobe, so the sample is in
   // rd_data two cycles later - no sooner than the next strobe may occur.
   assign rd_addr = byte_idx[ADDR_W:1] - ADDR_W'(2);
   assign rd_ext  = 16'(rd_data);

   always_comb begin
      cur_byte = 8'h00;
      if (byte_idx == 17'd0) begin
         cur_byte = HDR_BYTE;
      end else if (byte_idx == 17'd1) begin
         cur_byte = {overflow, aline_idx};
      end else if (byte_idx == 17'd2) begin
         cur_byte = sample_count[15:8];
      end else if (byte_idx == 17'd3) begin
         cur_byte = sample_count[7:0];
      end else if (byte_idx[0] == 1'b0) begin
         cur_byte = rd_ext[15:8];
      end else begin
         cur_byte = rd_ext[7:0];
      end
   end

   // Strobe is combinational on tx_busy so it can never coincide with a busy
   // UART; tx_start_q enforces at least one idle cycle between strobes.
   assign tx_start = (state == SEND) & bytes_left & ~tx_busy & ~tx_start_q & ~rst;
   assign tx_data  = tx_start ? cur_byte : tx_data_q;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (afe_rise) state_nxt = CAPTURE;
         CAPTURE: if (!afe_switch) state_nxt = SEND;
         SEND:    if (!bytes_left && !tx_busy && !tx_start_q) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         afe_switch_q   <= 1'b0;
         wr_addr        <= '0;
         sample_count   <= 16'd0;
         aline_idx      <= 7'd0;
         overflow       <= 1'b0;
         mem_clear      <= 1'b1;
         capture_missed <= 1'b0;
         byte_idx       <= 17'd0;
         tx_start_q     <= 1'b0;
         tx_data_q      <= 8'h00;
      end else begin
         state        <= state_nxt;
         afe_switch_q <= afe_switch;
         tx_start_q   <= tx_start;
         tx_data_q    <= tx_data;

         if (afe_rise && state != IDLE) begin
            capture_missed <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (!transmit_in_progress) begin
                  aline_idx <= 7'd0;
               end
               if (afe_rise) begin
                  mem_clear <= 1'b0;
                  wr_addr   <= '0;
                  overflow  <= 1'b0;
               end
            end
            CAPTURE: begin
               if (!afe_switch) begin
                  sample_count <= 16'(wr_addr);
                  byte_idx     <= 17'd0;
               end else if (adc_valid) begin
                  if (!wr_full) begin
                     wr_addr <= wr_addr + (ADDR_W+1)'(1);
                  end else begin
                     overflow <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (tx_start) begin
                  byte_idx <= byte_idx + 17'd1;
               end
            end
            DONE: begin
               mem_clear <= 1'b1;
               aline_idx <= aline_idx + 7'd1;
            end
            default: ;
         endcase
      end
   end

   // Sample RAM: no reset, synchronous read.
   always_ff @(posedge clk) begin
      if (state == CAPTURE && afe_switch && adc_valid && !wr_full) begin
         mem[wr_addr[ADDR_W-1:0]] <= adc_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: tb/tb_aline_echo_capture.sv
// tb/tb_aline_echo_capture.sv - self-checking bench for aline_echo_capture

module tb_aline_echo_capture;

   localparam int ADC_WIDTH = 10;
   localparam int DEPTH     = 8;
   localparam int ADDR_W    = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 afe_switch;
   logic                 transmit_in_progress;
   logic [ADC_WIDTH-1:0] adc_data;
   logic                 adc_valid;
   logic [7:0]           tx_data;
   logic                 tx_start;
   logic                 tx_busy;
   logic                 uart_busy;
   logic                 force_busy;
   logic                 mem_clear;
   logic                 capturing;
   logic                 capture_missed;

   assign tx_busy = uart_busy | force_busy;

   aline_echo_capture #(
      .ADC_WIDTH (ADC_WIDTH),
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W),
      .HDR_BYTE  (8'hA5)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .afe_switch           (afe_switch),
      .transmit_in_progress (transmit_in_progress),
      .adc_data             (adc_data),
      .adc_valid            (adc_valid),
      .tx_data              (tx_data),
      .tx_start             (tx_start),
      .tx_busy              (tx_busy),
      .mem_clear            (mem_clear),
      .capturing            (capturing),
      .capture_missed       (capture_missed)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          starts_total = 0;
   int          model_next_idx = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  frame_q[$];
   logic [7:0]  last_hdr1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   // Reference frame built straight from the frame format.
   task automatic build_frame(input int idx, input logic [9:0] vals[$]);
      int         cnt;
      logic       ovf;
      logic [15:0] c16;
      logic [6:0] i7;
      logic [9:0] s;
      cnt = (vals.size() > DEPTH) ? DEPTH : vals.size();
      ovf = (vals.size() > DEPTH);
      c16 = 16'(cnt);
      i7  = 7'(idx);
      frame_q.delete();
      frame_q.push_back(8'hA5);
      frame_q.push_back({ovf, i7});
      frame_q.push_back(c16[15:8]);
      frame_q.push_back(c16[7:0]);
      for (int k = 0; k < cnt; k++) begin
         s = vals[k];
         frame_q.push_back({6'b0, s[9:8]});
         frame_q.push_back(s[7:0]);
      end
   endtask

   // UART stand-in: busy from the cycle after each strobe for 1..4 cycles.
   initial begin
      uart_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start && !rst) begin
            @(posedge clk);
            #1 uart_busy = 1'b1;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1 uart_busy = 1'b0;
         end
      end
   end

   // Byte stream compare against the expected queue, every cycle.
   initial begin
      logic       prev_start;
      logic [7:0] last_byte;
      prev_start = 1'b0;
      last_byte  = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_start = 1'b0;
            last_byte  = 8'h00;
         end else begin
            if (tx_start) begin
               check("start_vs_busy", 32'(tx_busy), 32'd0);
               check("start_spacing", 32'(prev_start), 32'd0);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_byte: got %02h expected none", tx_data);
               end else begin
                  check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
               end
               last_byte = tx_data;
               starts_total++;
            end else begin
               check("tx_data_hold", 32'(tx_data), 32'(last_byte));
            end
            prev_start = tx_start;
         end
      end
   end

   task automatic set_tip(input logic v);
      @(posedge clk);
      #1 transmit_in_progress = v;
      repeat (2) @(posedge clk);
      if (!v) model_next_idx = 0;
   endtask

   task automatic run_aline(input logic [9:0] vals[$], input bit gappy);
      int i;
      int t;
      int idx;
      idx = model_next_idx;
      @(posedge clk);
      #1 afe_switch = 1'b1;
      adc_valid = 1'($urandom_range(0, 1));
      adc_data  = 10'($urandom);
      i = 0;
      while (i < vals.size()) begin
         @(posedge clk);
         #1;
         if (gappy && $urandom_range(0, 3) == 0) begin
            adc_valid = 1'b0;
            adc_data  = 10'($urandom);
         end else begin
            adc_valid = 1'b1;
            adc_data  = vals[i];
            i++;
         end
         @(negedge clk);
         check("capturing", 32'(capturing), 32'd1);
         check("mem_clear_low", 32'(mem_clear), 32'd0);
      end
      @(posedge clk);
      #1 afe_switch = 1'b0;
      adc_valid = 1'($urandom_range(0, 1));
      adc_data  = 10'($urandom);
      build_frame(idx, vals);
      last_hdr1 = frame_q[1];
      foreach (frame_q[k]) exp_q.push_back(frame_q[k]);
      @(negedge clk);
      check("capturing_fall", 32'(capturing), 32'd1);
      @(posedge clk);
      #1 adc_valid = 1'b0;
      t = 0;
      while (!mem_clear && t < 4000) begin
         @(negedge clk);
         t++;
      end
      if (!mem_clear) fail_now("mem_clear_return");
      check("frame_complete", 32'(exp_q.size()), 32'd0);
      check("capturing_off", 32'(capturing), 32'd0);
      model_next_idx = transmit_in_progress ? (idx + 1) % 128 : 0;
   endtask

   task automatic wait_starts(input int n, input string name);
      int s0;
      int t;
      s0 = starts_total;
      t = 0;
      while (starts_total < s0 + n && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (starts_total < s0 + n) fail_now(name);
   endtask

   initial begin
      logic [9:0] vq[$];
      logic [7:0] lit1 [14];
      int         s0;

      rst = 1'b1;
      afe_switch = 1'b0;
      transmit_in_progress = 1'b0;
      adc_valid = 1'b0;
      adc_data = '0;
      force_busy = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_mem_clear", 32'(mem_clear), 32'd1);
      check("rst_capturing", 32'(capturing), 32'd0);
      check("rst_missed", 32'(capture_missed), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Pin the model with hand-derived frames.
      lit1 = '{8'hA5, 8'h00, 8'h00, 8'h05, 8'h03, 8'hFF, 8'h00, 8'h01,
               8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
      vq = {10'h3FF, 10'h001, 10'h002, 10'h003, 10'h004};
      build_frame(0, vq);
      check("model_len", 32'(frame_q.size()), 32'd14);
      for (int k = 0; k < 14; k++) check("model_byte", 32'(frame_q[k]), 32'(lit1[k]));
      vq = {};
      for (int k = 1; k <= 10; k++) vq.push_back(10'(k));
      build_frame(5, vq);
      check("model_ovf_hdr", 32'(frame_q[1]), 32'h85);
      check("model_ovf_cnt", 32'(frame_q[3]), 32'h08);
      check("model_ovf_len", 32'(frame_q.size()), 32'd20);

      set_tip(1'b1);

      // Basic A-line.
      vq = {10'h3FF, 10'h001, 10'h002, 10'h003, 10'h004};
      run_aline(vq, 1'b0);
      check("hdr1_first", 32'(last_hdr1), 32'h00);

      // Overflow: more valid samples than DEPTH.
      vq = {};
      for (int k = 0; k < 11; k++) vq.push_back(10'($urandom));
      run_aline(vq, 1'b0);
      check("hdr1_overflow", 32'(last_hdr1), 32'h81);

      // Empty A-line.
      vq = {};
      run_aline(vq, 1'b0);
      check("hdr1_empty", 32'(last_hdr1), 32'h02);

      // Dropping transmit_in_progress restarts the index.
      set_tip(1'b0);
      set_tip(1'b1);
      vq = {10'h155};
      run_aline(vq, 1'b1);
      check("hdr1_restart", 32'(last_hdr1), 32'h00);

      // Missed rise during SEND plus a long UART stall.
      check("missed_before", 32'(capture_missed), 32'd0);
      vq = {};
      for (int k = 0; k < 6; k++) vq.push_back(10'($urandom));
      fork
         run_aline(vq, 1'b0);
         begin
            wait_starts(1, "first_start");
            @(posedge clk);
            #1 afe_switch = 1'b1;
            @(posedge clk);
            #1 afe_switch = 1'b0;
            @(negedge clk);
            check("missed_set", 32'(capture_missed), 32'd1);
            @(posedge clk);
            #1 force_busy = 1'b1;
            s0 = starts_total;
            repeat (20) @(posedge clk);
            #1 force_busy = 1'b0;
            check("stall_no_start", 32'(starts_total - s0), 32'd0);
         end
      join

      // Reset in the middle of SEND.
      vq = {};
      for (int k = 0; k < 8; k++) vq.push_back(10'($urandom));
      fork
         run_aline(vq, 1'b1);
         begin
            wait_starts(3, "third_start");
            @(posedge clk);
            #1 rst = 1'b1;
            exp_q.delete();
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            check("mid_rst_capturing", 32'(capturing), 32'd0);
            check("mid_rst_mem_clear", 32'(mem_clear), 32'd1);
            check("mid_rst_tx_start", 32'(tx_start), 32'd0);
            check("mid_rst_missed", 32'(capture_missed), 32'd0);
            s0 = starts_total;
            repeat (40) @(negedge clk);
            check("mid_rst_silent", 32'(starts_total - s0), 32'd0);
         end
      join
      model_next_idx = 0;

      // Index wrap 127 -> 0.
      vq = {};
      for (int n = 0; n < 129; n++) run_aline(vq, 1'b0);
      check("hdr1_wrap", 32'(last_hdr1), 32'h00);

      // Randomised A-lines.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            set_tip(1'b0);
            set_tip(1'b1);
         end
         vq = {};
         for (int k = 0; k < $urandom_range(0, 12); k++) vq.push_back(10'($urandom));
         run_aline(vq, 1'($urandom_range(0, 1)));
      end

      repeat (10) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
